// File: rtl/dsm_dac_mc_if.sv
// Sample-source handshake for dsm_dac_mc: one word carries a sample for every channel,
// with channel c in bits [c*WIDTH +: WIDTH].
`default_nettype none

interface dsm_dac_mc_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

`default_nettype wire

// File: rtl/dsm_dac_mc.sv
// Multi-channel delta-sigma DAC: one staging register and an OSR pacing counter shared by
// independent per-channel first/second-order modulators, each driving a 1-bit density output.
`default_nettype none

module dsm_dac_mc #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int OSR      = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                order2,
    dsm_dac_mc_if.slave         s_if,
    output logic [CHANNELS-1:0] dsm_out,
    output logic                sample_tick,
    output logic                underrun
);
    localparam int CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

    localparam int I1_W  = WIDTH + 2;
    localparam int I2_W  = WIDTH + 4;
    localparam int SUM_W = WIDTH + 6;

    localparam logic signed [SUM_W-1:0] HALF   = SUM_W'(2 ** (WIDTH - 1));
    localparam logic signed [SUM_W-1:0] I1_MAX = SUM_W'(2 ** (I1_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] I1_MIN = SUM_W'(-(2 ** (I1_W - 1)));
    localparam logic signed [SUM_W-1:0] I2_MAX = SUM_W'(2 ** (I2_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] I2_MIN = SUM_W'(-(2 ** (I2_W - 1)));

    // Integrators clamp instead of wrapping so an overloaded loop recovers cleanly.
    function automatic logic signed [I1_W-1:0] sat_i1(input logic signed [SUM_W-1:0] v);
        logic signed [I1_W-1:0] r;
        if (v > I1_MAX)      r = I1_MAX[I1_W-1:0];
        else if (v < I1_MIN) r = I1_MIN[I1_W-1:0];
        else                 r = v[I1_W-1:0];
        return r;
    endfunction

    function automatic logic signed [I2_W-1:0] sat_i2(input logic signed [SUM_W-1:0] v);
        logic signed [I2_W-1:0] r;
        if (v > I2_MAX)      r = I2_MAX[I2_W-1:0];
        else if (v < I2_MIN) r = I2_MIN[I2_W-1:0];
        else                 r = v[I2_W-1:0];
        return r;
    endfunction

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      stg_full_q, stg_full_d;
    logic [CHANNELS*WIDTH-1:0] stg_data_q, stg_data_d;
    logic                      ord_q, ord_d;
    logic                      sample_tick_q, sample_tick_d;
    logic                      underrun_q, underrun_d;

    logic tick;
    logic xfer;
    logic load_act;
    logic clr;

    // A transfer needs an empty stager, so it can never race with the tick that drains it.
    always_comb begin
        tick     = en && (cnt_q == CNT_LAST);
        xfer     = s_if.in_valid && !stg_full_q;
        load_act = tick && stg_full_q;
        clr      = tick && (order2 != ord_q);

        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        stg_full_d    = xfer || (stg_full_q && !load_act);
        stg_data_d    = xfer ? s_if.in_data : stg_data_q;
        ord_d         = tick ? order2 : ord_q;
        underrun_d    = underrun_q || (tick && !stg_full_q);
        sample_tick_d = tick;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            stg_full_q    <= 1'b0;
            stg_data_q    <= '0;
            ord_q         <= 1'b0;
            sample_tick_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            stg_full_q    <= stg_full_d;
            stg_data_q    <= stg_data_d;
            ord_q         <= ord_d;
            sample_tick_q <= sample_tick_d;
            underrun_q    <= underrun_d;
        end
    end

    assign s_if.in_ready = !stg_full_q;
    assign sample_tick   = sample_tick_q;
    assign underrun      = underrun_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0]        act_q, act_d;
        logic [WIDTH-1:0]        acc_q, acc_d;
        logic signed [I1_W-1:0]  i1_q, i1_d, i1_n;
        logic signed [I2_W-1:0]  i2_q, i2_d, i2_n;
        logic                    bit_q, bit_d;
        logic                    out_q, out_d;
        logic [WIDTH:0]          sum1;
        logic signed [SUM_W-1:0] xc;
        logic signed [SUM_W-1:0] fb;

        // bit_q keeps the loop's last decision through en=0 while the pin itself is forced low.
        always_comb begin
            act_d = load_act ? stg_data_q[c*WIDTH +: WIDTH] : act_q;

            sum1 = {1'b0, acc_q} + {1'b0, act_q};
            xc   = $signed(SUM_W'(act_q)) - HALF;
            fb   = bit_q ? HALF : -HALF;
            i1_n = sat_i1(SUM_W'(i1_q) + xc - fb);
            i2_n = sat_i2(SUM_W'(i2_q) + SUM_W'(i1_n) - fb);

            acc_d = acc_q;
            i1_d  = i1_q;
            i2_d  = i2_q;
            bit_d = bit_q;
            out_d = 1'b0;

            if (clr) begin
                acc_d = '0;
                i1_d  = '0;
                i2_d  = '0;
                bit_d = 1'b0;
            end else if (en) begin
                if (ord_q) begin
                    i1_d  = i1_n;
                    i2_d  = i2_n;
                    bit_d = !i2_n[I2_W-1];
                end else begin
                    acc_d = sum1[WIDTH-1:0];
                    bit_d = sum1[WIDTH];
                end
                out_d = bit_d;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_q <= '0;
                acc_q <= '0;
                i1_q  <= '0;
                i2_q  <= '0;
                bit_q <= 1'b0;
                out_q <= 1'b0;
            end else begin
                act_q <= act_d;
                acc_q <= acc_d;
                i1_q  <= i1_d;
                i2_q  <= i2_d;
                bit_q <= bit_d;
                out_q <= out_d;
            end
        end

        assign dsm_out[c] = out_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_dsm_dac_mc.sv
// Bench for dsm_dac_mc: directed scenarios plus random traffic against a cycle-stepped
// behavioural model built from plain integer arithmetic.
`timescale 1ns/1ps

module tb_dsm_dac_mc;
    localparam int W   = 8;
    localparam int CH  = 2;
    localparam int OSR = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          order2 = 1'b0;
    logic [CH-1:0] dsm_out;
    logic          sample_tick;
    logic          underrun;

    dsm_dac_mc_if #(.WIDTH(W), .CHANNELS(CH)) bus();

    dsm_dac_mc #(.WIDTH(W), .CHANNELS(CH), .OSR(OSR)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .order2(order2), .s_if(bus),
        .dsm_out(dsm_out), .sample_tick(sample_tick), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Reference model state
    int          m_cnt;
    int          m_stg[CH];
    int          m_act[CH];
    int          m_acc[CH];
    int          m_i1[CH];
    int          m_i2[CH];
    bit          m_full, m_under, m_stick, m_ord;
    bit [CH-1:0] m_bit, m_dout;

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [CH*W-1:0] mk(int c0, int c1);
        return {W'(c1), W'(c0)};
    endfunction

    task automatic m_reset();
        m_cnt = 0; m_full = 0; m_under = 0; m_stick = 0; m_ord = 0;
        m_bit = '0; m_dout = '0;
        for (int c = 0; c < CH; c++) begin
            m_stg[c] = 0; m_act[c] = 0; m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0;
        end
    endtask

    task automatic m_step();
        bit tick, clr, xfer;
        int x, xc, fb, s;
        tick = en && (m_cnt == OSR - 1);
        clr  = tick && (order2 != m_ord);
        xfer = bus.in_valid && !m_full;
        for (int c = 0; c < CH; c++) begin
            x = m_act[c];
            if (clr) begin
                m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_bit[c] = 0; m_dout[c] = 0;
            end else if (en) begin
                if (m_ord) begin
                    xc = x - 2 ** (W - 1);
                    fb = m_bit[c] ? 2 ** (W - 1) : -(2 ** (W - 1));
                    m_i1[c]  = clamp(m_i1[c] + xc - fb, -(2 ** (W + 1)), 2 ** (W + 1) - 1);
                    m_i2[c]  = clamp(m_i2[c] + m_i1[c] - fb, -(2 ** (W + 3)), 2 ** (W + 3) - 1);
                    m_bit[c] = (m_i2[c] >= 0);
                end else begin
                    s        = m_acc[c] + x;
                    m_bit[c] = (s >= 2 ** W);
                    m_acc[c] = s % (2 ** W);
                end
                m_dout[c] = m_bit[c];
            end else begin
                m_dout[c] = 0;
            end
        end
        if (tick) begin
            if (m_full) begin
                for (int c = 0; c < CH; c++) m_act[c] = m_stg[c];
                m_full = 0;
            end else begin
                m_under = 1;
            end
            m_ord = order2;
        end
        if (xfer) begin
            for (int c = 0; c < CH; c++) m_stg[c] = int'(bus.in_data[c*W +: W]);
            m_full = 1;
        end
        m_stick = tick;
        if (en) m_cnt = (m_cnt + 1) % OSR;
    endtask

    task automatic cyc();
        m_step();
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic do_reset();
        rst_n = 0; en = 0; order2 = 0; bus.in_valid = 0; bus.in_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        m_reset();
    endtask

    task automatic wait_tick(output bit ok);
        ok = 0;
        for (int i = 0; i < 2 * OSR; i++) begin
            cyc();
            if (sample_tick === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_tick: no sample_tick within %0d cycles at cyc %0d", 2 * OSR, cyc_n);
        end
    endtask

    task automatic test_reset();
        int  tick_cnt = 0, bad_tick = 0;
        bit  any_out = 0;
        rst_n = 0; en = 0; order2 = 0; bus.in_valid = 0; bus.in_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (dsm_out !== '0) begin errors++; $display("FAIL reset_dsm_out got=%b exp=00", dsm_out); end
        checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL reset_sample_tick got=%b exp=0", sample_tick); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        rst_n = 1; m_reset(); en = 1;
        for (int k = 1; k <= 250; k++) begin
            cyc();
            if (dsm_out !== '0) any_out = 1;
            if (sample_tick === 1'b1) begin
                tick_cnt++;
                if (k % OSR != 0) bad_tick++;
            end
            if (k == OSR - 1) begin
                checks++;
                if (underrun !== 1'b0) begin errors++; $display("FAIL idle_underrun_early got=%b exp=0", underrun); end
            end
        end
        checks++; if (tick_cnt != 2) begin errors++; $display("FAIL idle_tick_count got=%0d exp=2", tick_cnt); end
        checks++; if (bad_tick != 0) begin errors++; $display("FAIL idle_tick_period misplaced=%0d exp=0", bad_tick); end
        checks++; if (any_out) begin errors++; $display("FAIL idle_dsm_out got=nonzero exp=0"); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL idle_underrun got=%b exp=1", underrun); end
    endtask

    task automatic test_first_order();
        bit ok;
        int ones0 = 0, ones1 = 0;
        do_reset(); en = 1; order2 = 0;
        bus.in_valid = 1; bus.in_data = mk(64, 255);
        cyc();
        bus.in_valid = 0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fo_ready_drop got=%b exp=0", bus.in_ready); end
        wait_tick(ok);
        for (int k = 0; k < 256; k++) begin
            cyc();
            ones0 += int'(dsm_out[0]);
            ones1 += int'(dsm_out[1]);
            if (k < 8) begin
                checks++;
                if (dsm_out[0] !== ((k % 4) == 3))
                    begin errors++; $display("FAIL fo_pattern step=%0d got=%b exp=%b", k, dsm_out[0], (k % 4) == 3); end
            end
        end
        checks++; if (ones0 != 64) begin errors++; $display("FAIL fo_ch0_density got=%0d exp=64", ones0); end
        checks++; if (ones1 != 255) begin errors++; $display("FAIL fo_ch1_density got=%0d exp=255", ones1); end
    endtask

    task automatic test_backpressure();
        logic [CH*W-1:0] wd[3];
        int idx = 0, low_cnt = 0, win = 0, diff;
        int tx[3], ones[3];
        bit xf;
        do_reset(); en = 1; order2 = 0;
        for (int i = 0; i < 3; i++) begin
            wd[i] = mk(32 + 96 * i, int'($urandom_range(0, 255)));
            tx[i] = -1; ones[i] = 0;
        end
        bus.in_valid = 1; bus.in_data = wd[0];
        for (int k = 1; k <= 400; k++) begin
            xf = bus.in_valid && bus.in_ready;
            cyc();
            checks++;
            if ({sample_tick, underrun, bus.in_ready, dsm_out} !== {m_stick, m_under, !m_full, m_dout})
                begin errors++; $display("FAIL bp_model cyc=%0d got=%b%b%b%b exp=%b%b%b%b", cyc_n, sample_tick, underrun, bus.in_ready, dsm_out, m_stick, m_under, !m_full, m_dout); end
            if (xf) begin
                if (idx < 3) tx[idx] = k;
                idx++;
                if (idx < 3) bus.in_data = wd[idx];
                else bus.in_valid = 0;
            end
            if (k <= 200 && bus.in_ready === 1'b0) low_cnt++;
            if (win >= 1 && win <= 3) ones[win-1] += int'(dsm_out[0]);
            if (sample_tick === 1'b1) win++;
        end
        checks++; if (idx != 3) begin errors++; $display("FAIL bp_transfers got=%0d exp=3", idx); end
        checks++; if (tx[0] != 1) begin errors++; $display("FAIL bp_first_xfer got=%0d exp=1", tx[0]); end
        checks++; if (tx[1] - tx[0] != OSR) begin errors++; $display("FAIL bp_gap01 got=%0d exp=%0d", tx[1] - tx[0], OSR); end
        checks++; if (tx[2] - tx[1] != OSR) begin errors++; $display("FAIL bp_gap12 got=%0d exp=%0d", tx[2] - tx[1], OSR); end
        checks++; if (low_cnt != 2 * (OSR - 1)) begin errors++; $display("FAIL bp_ready_low got=%0d exp=%0d", low_cnt, 2 * (OSR - 1)); end
        for (int i = 0; i < 3; i++) begin
            diff = ones[i] * 256 - OSR * (32 + 96 * i);
            checks++;
            if (diff > 256 || diff < -256)
                begin errors++; $display("FAIL bp_word_order word=%0d ones=%0d exp~%0d", i, ones[i], OSR * (32 + 96 * i) / 256); end
        end
    endtask

    task automatic test_second_order();
        bit ok;
        int ones0 = 0, ones1 = 0;
        do_reset(); en = 1; order2 = 1;
        bus.in_valid = 1; bus.in_data = mk(128, 32);
        cyc();
        bus.in_valid = 0;
        wait_tick(ok);
        for (int k = 0; k < 2560; k++) begin
            cyc();
            checks++;
            if ({sample_tick, underrun, bus.in_ready, dsm_out} !== {m_stick, m_under, !m_full, m_dout})
                begin errors++; $display("FAIL so_model cyc=%0d got=%b%b%b%b exp=%b%b%b%b", cyc_n, sample_tick, underrun, bus.in_ready, dsm_out, m_stick, m_under, !m_full, m_dout); end
            ones0 += int'(dsm_out[0]);
            ones1 += int'(dsm_out[1]);
        end
        checks++; if (ones0 < 1270 || ones0 > 1290) begin errors++; $display("FAIL so_ch0_density got=%0d exp=1280+-10", ones0); end
        checks++; if (ones1 < 310 || ones1 > 330) begin errors++; $display("FAIL so_ch1_density got=%0d exp=320+-10", ones1); end
    endtask

    task automatic test_mode_switch();
        bit ok;
        int n = 0, ones0 = 0;
        do_reset(); en = 1; order2 = 0;
        bus.in_valid = 1; bus.in_data = mk(255, 200);
        cyc();
        bus.in_valid = 0;
        wait_tick(ok);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ms_underrun_loaded got=%b exp=0", underrun); end
        for (int k = 0; k < 30; k++) cyc();
        order2 = 1;
        ok = 0;
        for (int k = 0; k < OSR; k++) begin
            cyc();
            checks++;
            if ({sample_tick, underrun, bus.in_ready, dsm_out} !== {m_stick, m_under, !m_full, m_dout})
                begin errors++; $display("FAIL ms_model cyc=%0d got=%b%b%b%b exp=%b%b%b%b", cyc_n, sample_tick, underrun, bus.in_ready, dsm_out, m_stick, m_under, !m_full, m_dout); end
            if (sample_tick === 1'b1) begin ok = 1; break; end
            n++;
            ones0 += int'(dsm_out[0]);
        end
        checks++; if (!ok) begin errors++; $display("FAIL ms_tick_timeout got=none exp=tick"); end
        checks++; if (ones0 < n - 1) begin errors++; $display("FAIL ms_order_early ones=%0d of %0d exp>=%0d", ones0, n, n - 1); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ms_underrun got=%b exp=1", underrun); end
        for (int k = 0; k < 200; k++) begin
            cyc();
            checks++;
            if ({sample_tick, underrun, bus.in_ready, dsm_out} !== {m_stick, m_under, !m_full, m_dout})
                begin errors++; $display("FAIL ms_model2 cyc=%0d got=%b%b%b%b exp=%b%b%b%b", cyc_n, sample_tick, underrun, bus.in_ready, dsm_out, m_stick, m_under, !m_full, m_dout); end
        end
    endtask

    task automatic test_en_pause();
        bit ok;
        int t0, t1 = -1, step = 0, mism = 0, pause_bad = 0;
        do_reset(); en = 1; order2 = 0;
        bus.in_valid = 1; bus.in_data = mk(64, 128);
        cyc();
        bus.in_valid = 0;
        wait_tick(ok);
        t0 = cyc_n;
        for (int k = 0; k < 37; k++) begin
            cyc(); step++;
            if (dsm_out[0] !== (step % 4 == 0)) mism++;
        end
        en = 0;
        for (int k = 0; k < 50; k++) begin
            cyc();
            checks++;
            if ({sample_tick, underrun, bus.in_ready, dsm_out} !== {m_stick, m_under, !m_full, m_dout})
                begin errors++; $display("FAIL en_model cyc=%0d got=%b%b%b%b exp=%b%b%b%b", cyc_n, sample_tick, underrun, bus.in_ready, dsm_out, m_stick, m_under, !m_full, m_dout); end
            if (dsm_out !== '0 || sample_tick !== 1'b0) pause_bad++;
        end
        en = 1;
        for (int k = 0; k < 2 * OSR; k++) begin
            cyc(); step++;
            if (step <= 120 && dsm_out[0] !== (step % 4 == 0)) mism++;
            if (sample_tick === 1'b1) begin t1 = cyc_n; break; end
        end
        checks++; if (pause_bad != 0) begin errors++; $display("FAIL en_pause_quiet bad_cycles=%0d exp=0", pause_bad); end
        checks++; if (t1 - t0 != OSR + 50) begin errors++; $display("FAIL en_counter_frozen tick_gap=%0d exp=%0d", t1 - t0, OSR + 50); end
        checks++; if (mism != 0) begin errors++; $display("FAIL en_resume_sequence mismatches=%0d exp=0", mism); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) order2 = ~order2;
            bus.in_valid = ($urandom_range(0, 3) == 0);
            bus.in_data  = (CH*W)'($urandom);
            cyc();
            checks++;
            if ({sample_tick, underrun, bus.in_ready, dsm_out} !== {m_stick, m_under, !m_full, m_dout})
                begin errors++; $display("FAIL rnd_model cyc=%0d got=%b%b%b%b exp=%b%b%b%b", cyc_n, sample_tick, underrun, bus.in_ready, dsm_out, m_stick, m_under, !m_full, m_dout); end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset(); en = 1; order2 = 0;
        bus.in_valid = 1; bus.in_data = mk(200, 100);
        cyc();
        bus.in_valid = 0;
        for (int k = 0; k < 205; k++) cyc();
        bus.in_valid = 1; bus.in_data = mk(17, 99);
        cyc();
        bus.in_valid = 0;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ar_pre_underrun got=%b exp=1", underrun); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ar_pre_ready got=%b exp=0", bus.in_ready); end
        #3 rst_n = 0;
        #1;
        checks++; if (dsm_out !== '0) begin errors++; $display("FAIL ar_dsm_out got=%b exp=00", dsm_out); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ar_underrun got=%b exp=0", underrun); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL ar_sample_tick got=%b exp=0", sample_tick); end
        @(negedge clk);
        rst_n = 1; m_reset();
        wait_tick(ok);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ar_no_pending got=%b exp=1", underrun); end
        checks++; if (dsm_out !== '0) begin errors++; $display("FAIL ar_post_out got=%b exp=00", dsm_out); end
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_data  = '0;
        test_reset();
        test_first_order();
        test_backpressure();
        test_second_order();
        test_mode_switch();
        test_en_pause();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete at cyc %0d", cyc_n);
        $fatal(1, "watchdog expired");
    end

endmodule
